// File: rtl/gmii_tx_framer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_tx_framer_pkg
//  Description : Shared byte codes, GMII constants and framer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package gmii_tx_framer_pkg;

  localparam logic [1:0] c_code_data   = 2'b00;
  localparam logic [1:0] c_code_sop    = 2'b01;
  localparam logic [1:0] c_code_eop    = 2'b10;
  localparam logic [1:0] c_code_badeop = 2'b11;

  localparam logic [7:0] c_gmii_preamble = 8'h55;
  localparam logic [7:0] c_gmii_sfd      = 8'hD5;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_SFD      = 3'd2,
    ST_DATA     = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_IFG      = 3'd5
  } state_t;

  // Both EOP flavours share the upper code bit.
  function automatic logic is_eop(input logic [1:0] code);
    return code[1];
  endfunction

endpackage
`default_nettype wire

// File: rtl/gmii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : gmii_tx_framer
//  Description : Wraps an upstream byte stream into GMII frames with preamble,
//                SFD, underrun abort and enforced inter-frame gap.
//  Revision    : 1.0 - initial release
// ============================================================================
module gmii_tx_framer
  import gmii_tx_framer_pkg::*;
#(
  parameter int IFG_CYCLES   = 12,
  parameter int PREAMBLE_LEN = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_srdy,
  output logic        p_drdy,
  input  logic [7:0]  p_data,
  input  logic [1:0]  p_code,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic [15:0] frame_cnt,
  output logic [15:0] bad_cnt,
  output logic [15:0] underrun_cnt
);

  localparam logic [15:0] c_pre_load = 16'(PREAMBLE_LEN - 1);
  localparam logic [15:0] c_ifg_load = 16'(IFG_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_nxt;
  logic        r_tx_en;
  logic        w_tx_en_nxt;
  logic [7:0]  r_txd;
  logic [7:0]  w_txd_nxt;
  logic [15:0] r_frame_cnt;
  logic [15:0] r_bad_cnt;
  logic [15:0] r_underrun_cnt;
  logic        w_drdy;
  logic        w_frame_inc;
  logic        w_bad_inc;
  logic        w_under_inc;
  logic        w_goto_ifg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 16'd0;
      r_tx_en        <= 1'b0;
      r_txd          <= 8'h00;
      r_frame_cnt    <= 16'd0;
      r_bad_cnt      <= 16'd0;
      r_underrun_cnt <= 16'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_tx_en <= w_tx_en_nxt;
      r_txd   <= w_txd_nxt;
      if (w_frame_inc) r_frame_cnt    <= r_frame_cnt + 16'd1;
      if (w_bad_inc)   r_bad_cnt      <= r_bad_cnt + 16'd1;
      if (w_under_inc) r_underrun_cnt <= r_underrun_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_tx_en_nxt = 1'b0;
    w_txd_nxt   = 8'h00;
    w_drdy      = 1'b0;
    w_frame_inc = 1'b0;
    w_bad_inc   = 1'b0;
    w_under_inc = 1'b0;
    w_goto_ifg  = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // The SOP byte is held upstream and only consumed once DATA is reached.
        if (p_srdy && (p_code == c_code_sop)) begin
          w_tx_en_nxt = 1'b1;
          w_txd_nxt   = c_gmii_preamble;
          w_cnt_nxt   = c_pre_load;
          w_state_nxt = (PREAMBLE_LEN <= 1) ? ST_SFD : ST_PREAMBLE;
        end else begin
          w_drdy = 1'b1;
        end
      end

      ST_PREAMBLE: begin
        w_tx_en_nxt = 1'b1;
        w_txd_nxt   = c_gmii_preamble;
        if (r_cnt <= 16'd1) begin
          w_cnt_nxt   = 16'd0;
          w_state_nxt = ST_SFD;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end

      ST_SFD: begin
        w_tx_en_nxt = 1'b1;
        w_txd_nxt   = c_gmii_sfd;
        w_state_nxt = ST_DATA;
      end

      ST_DATA: begin
        w_drdy = 1'b1;
        if (p_srdy) begin
          w_tx_en_nxt = 1'b1;
          w_txd_nxt   = p_data;
          case (p_code)
            c_code_eop: begin
              w_frame_inc = 1'b1;
              w_goto_ifg  = 1'b1;
            end
            c_code_badeop: begin
              w_bad_inc  = 1'b1;
              w_goto_ifg = 1'b1;
            end
            c_code_sop, c_code_data: ;
          endcase
        end else begin
          w_under_inc = 1'b1;
          w_state_nxt = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        w_drdy = 1'b1;
        if (p_srdy && is_eop(p_code)) w_goto_ifg = 1'b1;
      end

      ST_IFG: begin
        if (r_cnt == 16'd0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 16'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    if (w_goto_ifg) begin
      w_cnt_nxt   = c_ifg_load;
      w_state_nxt = (IFG_CYCLES == 0) ? ST_IDLE : ST_IFG;
    end
  end

  assign p_drdy       = w_drdy;
  assign gmii_tx_en   = r_tx_en;
  assign gmii_txd     = r_txd;
  assign frame_cnt    = r_frame_cnt;
  assign bad_cnt      = r_bad_cnt;
  assign underrun_cnt = r_underrun_cnt;

endmodule
`default_nettype wire

// File: tb/tb_gmii_tx_framer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_gmii_tx_framer
//  Description : Directed self-checking bench for gmii_tx_framer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gmii_tx_framer;
  import gmii_tx_framer_pkg::*;

  localparam int IFG = 12;
  localparam int PRE = 7;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        p_srdy = 1'b0;
  logic        p_drdy;
  logic [7:0]  p_data = 8'h00;
  logic [1:0]  p_code = c_code_data;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic [15:0] frame_cnt;
  logic [15:0] bad_cnt;
  logic [15:0] underrun_cnt;

  int n_checks = 0;
  int n_errors = 0;

  bit         log_en = 1'b0;
  bit         q_en[$];
  logic [7:0] q_d[$];
  logic [7:0] exp_bytes[$];
  int         exp_lens[$];

  gmii_tx_framer #(.IFG_CYCLES(IFG), .PREAMBLE_LEN(PRE)) dut (
    .clk          (clk),
    .reset        (reset),
    .p_srdy       (p_srdy),
    .p_drdy       (p_drdy),
    .p_data       (p_data),
    .p_code       (p_code),
    .gmii_tx_en   (gmii_tx_en),
    .gmii_txd     (gmii_txd),
    .frame_cnt    (frame_cnt),
    .bad_cnt      (bad_cnt),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (log_en) begin
      q_en.push_back(gmii_tx_en);
      q_d.push_back(gmii_txd);
    end
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, act, act, exp, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    p_srdy = 1'b0;
    reset  = 1'b0;
    #1;
    chk("rst_tx_en", int'(gmii_tx_en), 0);
    chk("rst_txd", int'(gmii_txd), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_bad_cnt", int'(bad_cnt), 0);
    chk("rst_underrun_cnt", int'(underrun_cnt), 0);
    chk("rst_drdy", int'(p_drdy), 1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic clear_log();
    q_en.delete();
    q_d.delete();
    exp_bytes.delete();
    exp_lens.delete();
    log_en = 1'b1;
  endtask

  task automatic expect_frame(input int n, input logic [7:0] base);
    for (int i = 0; i < PRE; i++) exp_bytes.push_back(8'h55);
    exp_bytes.push_back(8'hD5);
    for (int i = 0; i < n; i++) exp_bytes.push_back(base + 8'(i));
    exp_lens.push_back(PRE + 1 + n);
  endtask

  // Presents one byte and holds it until a transfer edge (bounded).
  task automatic put_byte(input logic [7:0] d, input logic [1:0] c, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    p_srdy = 1'b1;
    p_data = d;
    p_code = c;
    for (int t = 0; t < 200 && !ok; t++) begin
      #2;
      if (p_drdy) ok = 1'b1;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
  endtask

  task automatic send_frame(input int n, input logic [7:0] base, input logic [1:0] eop,
                            input int stall_after, input int sop_mid);
    bit ok;
    logic [1:0] c;
    for (int i = 0; i < n; i++) begin
      c = (i == 0) ? c_code_sop : (i == n - 1) ? eop : (i == sop_mid) ? c_code_sop : c_code_data;
      put_byte(base + 8'(i), c, ok);
      if (!ok) begin
        chk("xfer_timeout", 0, 1);
        return;
      end
      if (i + 1 == stall_after) begin
        @(negedge clk);
        p_srdy = 1'b0;
        repeat (3) @(posedge clk);
      end
    end
  endtask

  // Counts cycles with p_drdy low right after the EOP edge.
  task automatic measure_ifg(input string tag);
    int n = 0;
    bit done = 1'b0;
    @(negedge clk);
    p_srdy = 1'b0;
    for (int t = 0; t < 100 && !done; t++) begin
      #2;
      if (p_drdy) done = 1'b1;
      else begin
        n++;
        @(negedge clk);
      end
    end
    if (!done) n = -1;
    chk(tag, n, IFG);
  endtask

  task automatic check_log(input string tag, input int exp_gap);
    int lens[$];
    int gaps[$];
    logic [7:0] got[$];
    int run = 0, zeros = 0, bad_idle = 0, diff;
    bit seen = 1'b0;
    log_en = 1'b0;
    foreach (q_en[i]) begin
      if (q_en[i]) begin
        if (run == 0 && seen) gaps.push_back(zeros);
        run++;
        got.push_back(q_d[i]);
      end else begin
        if (q_d[i] != 8'h00) bad_idle++;
        if (run > 0) begin
          lens.push_back(run);
          run = 0;
          seen = 1'b1;
          zeros = 0;
        end
        zeros++;
      end
    end
    if (run > 0) lens.push_back(run);
    chk({tag, "_bursts"}, lens.size(), exp_lens.size());
    foreach (exp_lens[k])
      chk($sformatf("%s_len%0d", tag, k), (k < lens.size()) ? lens[k] : -1, exp_lens[k]);
    diff = (got.size() > exp_bytes.size()) ? got.size() - exp_bytes.size()
                                           : exp_bytes.size() - got.size();
    foreach (exp_bytes[k])
      if (k < got.size() && got[k] !== exp_bytes[k]) diff++;
    chk({tag, "_bytes_wrong"}, diff, 0);
    chk({tag, "_idle_txd_nonzero"}, bad_idle, 0);
    if (exp_gap >= 0) begin
      chk({tag, "_ngaps"}, gaps.size(), exp_lens.size() - 1);
      foreach (gaps[k]) chk($sformatf("%s_gap%0d", tag, k), gaps[k], exp_gap);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int nok;

    // Long good frame
    do_reset();
    clear_log();
    expect_frame(64, 8'h10);
    send_frame(64, 8'h10, c_code_eop, -1, -1);
    measure_ifg("t1_ifg");
    repeat (4) @(negedge clk);
    check_log("t1", -1);
    chk("t1_frame_cnt", int'(frame_cnt), 1);
    chk("t1_bad_cnt", int'(bad_cnt), 0);
    chk("t1_underrun_cnt", int'(underrun_cnt), 0);

    // Back-to-back frames
    do_reset();
    clear_log();
    expect_frame(20, 8'h40);
    expect_frame(20, 8'h80);
    send_frame(20, 8'h40, c_code_eop, -1, -1);
    send_frame(20, 8'h80, c_code_eop, -1, -1);
    measure_ifg("t2_ifg");
    repeat (4) @(negedge clk);
    check_log("t2", IFG);
    chk("t2_frame_cnt", int'(frame_cnt), 2);

    // Underrun after 10 payload bytes
    do_reset();
    clear_log();
    expect_frame(10, 8'hA0);
    send_frame(20, 8'hA0, c_code_eop, 10, -1);
    measure_ifg("t3_ifg");
    repeat (4) @(negedge clk);
    check_log("t3", -1);
    chk("t3_underrun_cnt", int'(underrun_cnt), 1);
    chk("t3_frame_cnt", int'(frame_cnt), 0);

    // Bad EOP, with an SOP code mid-frame carried as data
    do_reset();
    clear_log();
    expect_frame(16, 8'hC0);
    send_frame(16, 8'hC0, c_code_badeop, -1, 7);
    measure_ifg("t4_ifg");
    repeat (4) @(negedge clk);
    check_log("t4", -1);
    chk("t4_bad_cnt", int'(bad_cnt), 1);
    chk("t4_frame_cnt", int'(frame_cnt), 0);

    // Junk before SOP is consumed silently
    do_reset();
    clear_log();
    nok = 0;
    for (int i = 0; i < 3; i++) begin
      put_byte(8'hF0 + 8'(i), c_code_data, ok);
      if (ok) nok++;
    end
    chk("t5_junk_accepted", nok, 3);
    expect_frame(10, 8'hE0);
    send_frame(10, 8'hE0, c_code_eop, -1, -1);
    measure_ifg("t5_ifg");
    repeat (4) @(negedge clk);
    check_log("t5", -1);
    chk("t5_frame_cnt", int'(frame_cnt), 1);

    // Reset during the 5th payload byte
    do_reset();
    send_frame(12, 8'h30, c_code_eop, -1, -1);
    measure_ifg("t6_pre_ifg");
    chk("t6_pre_frame_cnt", int'(frame_cnt), 1);
    clear_log();
    expect_frame(4, 8'h20);
    expect_frame(8, 8'h60);
    for (int i = 0; i < 4; i++) begin
      put_byte(8'h20 + 8'(i), (i == 0) ? c_code_sop : c_code_data, ok);
      if (!ok) chk("t6_xfer_timeout", 0, 1);
    end
    @(negedge clk);
    p_srdy = 1'b1;
    p_data = 8'h24;
    p_code = c_code_data;
    #2;
    reset = 1'b0;
    #1;
    chk("t6_rst_tx_en", int'(gmii_tx_en), 0);
    chk("t6_rst_txd", int'(gmii_txd), 0);
    chk("t6_rst_frame_cnt", int'(frame_cnt), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    nok = 0;
    for (int i = 4; i < 10; i++) begin
      put_byte(8'h20 + 8'(i), (i == 9) ? c_code_eop : c_code_data, ok);
      if (ok) nok++;
    end
    chk("t6_remainder_discarded", nok, 6);
    send_frame(8, 8'h60, c_code_eop, -1, -1);
    measure_ifg("t6_ifg");
    repeat (4) @(negedge clk);
    check_log("t6", -1);
    chk("t6_frame_cnt", int'(frame_cnt), 1);
    chk("t6_underrun_cnt", int'(underrun_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gmii_tx_framer.md
GMII_TX_FRAMER -- requirements
Module: gmii_tx_framer

Interface
REQ-001 Parameter IFG_CYCLES, default 12, idle cycles forced after every frame.
REQ-002 Parameter PREAMBLE_LEN, default 7, number of 0x55 bytes before SFD.
REQ-003 clk  input  1  single clock for all logic.
REQ-004 reset  input  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 p_srdy  input  1  upstream byte valid.
REQ-006 p_drdy  output  1  framer accepts byte; transfer when p_srdy and p_drdy are both 1 at a clk edge.
REQ-007 p_data  input  8  packet byte.
REQ-008 p_code  input  2  byte code: 01 SOP, 00 DATA, 10 EOP-good, 11 EOP-bad.
REQ-009 gmii_tx_en  output  1  GMII transmit enable, registered.
REQ-010 gmii_txd  output  8  GMII transmit data, registered.
REQ-011 frame_cnt  output  16  good frames sent, wraps at 0xFFFF.
REQ-012 bad_cnt  output  16  frames ended with EOP-bad, wraps.
REQ-013 underrun_cnt  output  16  frames aborted on underrun, wraps.

Function
REQ-014 States SHALL be IDLE, PREAMBLE, SFD, DATA, DRAIN, IFG.
REQ-015 IDLE: p_drdy=1 unless p_srdy=1 with p_code=SOP; non-SOP bytes consumed and discarded, no output, no count.
REQ-016 IDLE with p_srdy=1, p_code=SOP at edge N: SOP byte not consumed; go PREAMBLE; gmii_tx_en=1, gmii_txd=0x55 after edges N..N+PREAMBLE_LEN-1.
REQ-017 SFD: gmii_txd=0xD5 after edge N+PREAMBLE_LEN; state DATA during that cycle.
REQ-018 DATA: p_drdy=1; each transfer drives gmii_tx_en=1, gmii_txd=p_data after same edge (1-cycle latency); first payload byte (the SOP byte) on wire after edge N+PREAMBLE_LEN+1.
REQ-019 DATA: p_code=SOP treated as ordinary data byte.
REQ-020 DATA transfer with EOP-good: byte transmitted, frame_cnt+1, go IFG.
REQ-021 DATA transfer with EOP-bad: byte transmitted, bad_cnt+1, frame_cnt unchanged, go IFG.
REQ-022 DATA with p_srdy=0 at an edge (underrun): gmii_tx_en=0, gmii_txd=0x00 after that edge, underrun_cnt+1, go DRAIN.
REQ-023 DRAIN: p_drdy=1, bytes discarded, gmii_tx_en=0; on EOP (either) transfer go IFG, no further count.
REQ-024 IFG: p_drdy=0, gmii_tx_en=0, gmii_txd=0x00 for exactly IFG_CYCLES cycles, then IDLE.
REQ-025 PREAMBLE, SFD: p_drdy=0.
REQ-026 gmii_txd SHALL be 0x00 whenever gmii_tx_en=0.
REQ-027 Counters increment at most once per frame; wrap 0xFFFF->0x0000.

Reset
REQ-028 reset=0 SHALL immediately force IDLE, gmii_tx_en=0, gmii_txd=0x00, all counters 0, preamble/IFG counters 0.
REQ-029 Reset mid-frame SHALL truncate the frame with no count; upstream remainder handled by IDLE discard after release.
REQ-030 p_drdy is combinational from state; valid on first edge after reset release.

Structure
REQ-031 Shared package SHALL hold p_code constants (SOP/DATA/EOP/BADEOP), GMII constants 0x55 and 0xD5, and state enumeration.
REQ-032 Single flat module, no sub-module; one shared down-counter serves PREAMBLE and IFG.

Verification
REQ-033 SOP+62 DATA+EOP-good, p_srdy held 1 -> 7x0x55, 0xD5, 64 bytes contiguous with tx_en=1, then 12 idle cycles, frame_cnt=1.
REQ-034 Two back-to-back 20-byte frames -> second preamble starts exactly 12 cycles after first EOP byte leaves; frame_cnt=2.
REQ-035 p_srdy dropped after 10th payload byte, remainder delivered with EOP -> tx_en falls after 10 bytes, underrun_cnt=1, frame_cnt=0, 12 idle cycles after EOP consumed.
REQ-036 Frame ending EOP-bad -> all bytes transmitted, bad_cnt=1, frame_cnt=0.
REQ-037 3 DATA bytes without SOP in IDLE, then valid frame -> junk consumed, no tx_en, valid frame sent normally.
REQ-038 reset=0 during 5th payload byte -> tx_en=0 same cycle, counters 0; next SOP frame after release sent correctly.
